sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DW, default 8: data width in bits, legal range 1 to 64.
REQ-002 Parameter DEP, default 16: depth in words, a power of two, legal range 4 to 1024; AW = log2(DEP).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 w_en  input  1  write request.
REQ-006 r_en  input  1  read request.
REQ-007 data_in  input  DW  write data.
REQ-008 flush  input  1  synchronous clear of contents.
REQ-009 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-010 afull_th  input  AW+1  almost-full threshold.
REQ-011 aempty_th  input  AW+1  almost-empty threshold.
REQ-012 data_out  output  DW  read data.
REQ-013 full, empty, hf, amf, ame  output  1 each  status flags.
REQ-014 of, uf  output  1 each  sticky overflow and underflow flags.
REQ-015 count  output  AW+1  current fill level, 0 to DEP.

Function
REQ-016 Pointers w_ptr and r_ptr SHALL be AW+1 bits wide, binary, with the MSB as wrap bit; count = w_ptr - r_ptr, registered.
REQ-017 Write accepted iff w_en && !full at the edge: mem[w_ptr[AW-1:0]] <= data_in, then w_ptr increments.
REQ-018 Read accepted iff r_en && !empty at the edge, then r_ptr increments.
REQ-019 Simultaneous accepted read and write SHALL leave count unchanged; on full, only the read is accepted; on empty, only the write is accepted.
REQ-020 Flags SHALL be decoded from registered count: full = (count==DEP), empty = (count==0), hf = (count>=DEP/2), amf = (count>=afull_th), ame = (count<=aempty_th); flags are valid the cycle after the causing edge.
REQ-021 w_en && full at an edge SHALL set of; r_en && empty at an edge SHALL set uf; both flags hold until clr_err or reset.
REQ-022 If clr_err and a new error occur in the same cycle, the set SHALL win.
REQ-023 When flush is high at an edge, pointers and count SHALL clear, data_out SHALL clear to 0, and any w_en/r_en in that cycle SHALL be ignored; of/uf SHALL be unaffected.
REQ-024 Pointer wrap SHALL be seamless; DEP consecutive writes after DEP reads SHALL reuse locations 0 to DEP-1.

Reset
REQ-025 rstn low SHALL immediately clear w_ptr, r_ptr, count, data_out, of and uf, giving empty=1, ame=1 and full=hf=amf=0 (for any afull_th > 0).
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-transfer SHALL abort it with no partial pointer update.

Configuration
REQ-028 Macro FIFO_FWFT_EN defined: first-word fall-through; data_out = mem[r_ptr[AW-1:0]] combinationally while !empty and 0 while empty, and an accepted read advances to the next word.
REQ-029 Macro FIFO_FWFT_EN undefined: data_out is registered, loads mem[r_ptr] on an accepted read (one-cycle latency) and holds otherwise.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default DW/DEP constants and the clog2 function used to derive AW.
REQ-031 Storage SHALL be a sub-module fifo_mem: a DW x DEP register array with a synchronous write port and an asynchronous read port, with no reset.

Verification
REQ-032 Reset, then write 16 words 0x01 to 0x10 and read 16 words (DEP=16, non-FWFT) -> data_out 0x01 to 0x10 in order, one cycle after each read; full=1 after the 16th write; empty=1 after the 16th read.
REQ-033 Write a 17th word while full (0xAA) -> of=1, count stays 16, and 0xAA is never read back; then pulse clr_err -> of=0.
REQ-034 Read while empty -> uf=1, count=0, data_out unchanged.
REQ-035 Thresholds afull_th=12, aempty_th=3 with writes of 1 to 16 -> ame falls at count=4, hf rises at count=8, amf rises at count=12.
REQ-036 Fill to 10 words, then assert w_en and r_en for 6 cycles -> count stays 10; then flush -> count=0, empty=1 next cycle.
REQ-037 FIFO_FWFT_EN build, single write of 0x5C -> data_out=0x5C the cycle after the write edge, before any r_en.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
// Holds the default geometry and the log2 helper that sizes the pointers.
package fifo_pkg;

    localparam int FIFO_DEF_DW  = 8;
    localparam int FIFO_DEF_DEP = 16;

    // Status flags decoded from the registered fill level.
    typedef struct packed {
        logic full;
        logic empty;
        logic hf;
        logic amf;
        logic ame;
    } fifo_status_t;

    // Smallest n with 2**n >= value.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DW x DEP storage array for sync_fifo_param: one synchronous write port,
// one asynchronous read port, contents never reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DW  = FIFO_DEF_DW,
    parameter int DEP = FIFO_DEF_DEP,
    parameter int AW  = clog2(FIFO_DEF_DEP)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEP];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with threshold flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through; default is registered read data.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DW  = FIFO_DEF_DW,
    parameter int DEP = FIFO_DEF_DEP,
    localparam int AW = clog2(DEP)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          w_en,
    input  logic          r_en,
    input  logic [DW-1:0] data_in,
    input  logic          flush,
    input  logic          clr_err,
    input  logic [AW:0]   afull_th,
    input  logic [AW:0]   aempty_th,
    output logic [DW-1:0] data_out,
    output logic          full,
    output logic          empty,
    output logic          hf,
    output logic          amf,
    output logic          ame,
    output logic          of,
    output logic          uf,
    output logic [AW:0]   count
);

    localparam logic [AW:0] L_DEP  = (AW+1)'(DEP);
    localparam logic [AW:0] L_HALF = (AW+1)'(DEP / 2);
    localparam logic [AW:0] L_ONE  = (AW+1)'(1);

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_of;
    logic          r_uf;

    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_rd_ptr_nxt;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_of_set;
    logic          w_uf_set;
    logic [DW-1:0] w_mem_rdata;
    fifo_status_t  w_status;

    // Flags come from the registered count, so they settle one cycle after the edge.
    assign w_status.full  = (r_count == L_DEP);
    assign w_status.empty = (r_count == '0);
    assign w_status.hf    = (r_count >= L_HALF);
    assign w_status.amf   = (r_count >= afull_th);
    assign w_status.ame   = (r_count <= aempty_th);

    assign w_wr_acc = w_en && !w_status.full  && !flush;
    assign w_rd_acc = r_en && !w_status.empty && !flush;
    assign w_of_set = w_en && w_status.full  && !flush;
    assign w_uf_set = r_en && w_status.empty && !flush;

    assign w_wr_ptr_nxt = flush    ? '0 :
                          w_wr_acc ? r_wr_ptr + L_ONE : r_wr_ptr;
    assign w_rd_ptr_nxt = flush    ? '0 :
                          w_rd_acc ? r_rd_ptr + L_ONE : r_rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_wr_ptr_nxt - w_rd_ptr_nxt;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_of <= 1'b0;
            r_uf <= 1'b0;
        end else begin
            r_of <= w_of_set ? 1'b1 : (clr_err ? 1'b0 : r_of);
            r_uf <= w_uf_set ? 1'b1 : (clr_err ? 1'b0 : r_uf);
        end
    end

    fifo_mem #(
        .DW  (DW),
        .DEP (DEP),
        .AW  (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && rstn),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign data_out = w_status.empty ? '0 : w_mem_rdata;
`else
    logic [DW-1:0] r_dout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= '0;
        end else if (flush) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_mem_rdata;
        end
    end

    assign data_out = r_dout;
`endif

    assign full  = w_status.full;
    assign empty = w_status.empty;
    assign hf    = w_status.hf;
    assign amf   = w_status.amf;
    assign ame   = w_status.ame;
    assign of    = r_of;
    assign uf    = r_uf;
    assign count = r_count;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DW=8, DEP=16): vector table,
// directed corner sequences and randomized traffic against a queue model.
module tb_sync_fifo_param;

    localparam int DW  = 8;
    localparam int DEP = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW:0]   afull_th = 5'd12;
    logic [AW:0]   aempty_th = 5'd3;
    logic [DW-1:0] data_out;
    logic          full, empty, hf, amf, ame, of, uf;
    logic [AW:0]   count;

    sync_fifo_param #(.DW(DW), .DEP(DEP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .w_en      (w_en),
        .r_en      (r_en),
        .data_in   (data_in),
        .flush     (flush),
        .clr_err   (clr_err),
        .afull_th  (afull_th),
        .aempty_th (aempty_th),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .hf        (hf),
        .amf       (amf),
        .ame       (ame),
        .of        (of),
        .uf        (uf),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a queue of stored words plus the sticky flags.
    logic [DW-1:0] q [$];
    logic          m_of = 1'b0;
    logic          m_uf = 1'b0;
    logic [DW-1:0] m_dout = '0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int w, r, fl, ce, d;
        int cnt, of_e, uf_e, dout_reg, dout_fwft;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [DW-1:0] model_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() > 0) ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    task automatic model_edge(input logic w, input logic r, input logic fl,
                              input logic ce, input logic [DW-1:0] d);
        int sz;
        logic of_set, uf_set;
        sz = q.size();
        of_set = !fl && w && (sz == DEP);
        uf_set = !fl && r && (sz == 0);
        if (fl) begin
            q.delete();
            m_dout = '0;
        end else begin
            if (r && sz > 0) begin
                m_dout = q.pop_front();
            end
            if (w && sz < DEP) begin
                q.push_back(d);
            end
        end
        m_of = of_set ? 1'b1 : (ce ? 1'b0 : m_of);
        m_uf = uf_set ? 1'b1 : (ce ? 1'b0 : m_uf);
    endtask

    task automatic check_all(input string name);
        int sz;
        logic [AW:0] e_cnt;
        logic [DW-1:0] e_dout;
        logic [6:0] e_fl, a_fl;
        sz = q.size();
        e_cnt = (AW+1)'(sz);
        e_dout = model_dout();
        e_fl = {sz == DEP, sz == 0, sz >= DEP/2, sz >= int'(afull_th),
                sz <= int'(aempty_th), m_of, m_uf};
        a_fl = {full, empty, hf, amf, ame, of, uf};
        n_vec++;
        if (count !== e_cnt || data_out !== e_dout || a_fl !== e_fl) begin
            n_bad++;
            $display("FAIL %s: got count=%0d dout=%02h flags(full,empty,hf,amf,ame,of,uf)=%b, want count=%0d dout=%02h flags=%b",
                     name, count, data_out, a_fl, e_cnt, e_dout, e_fl);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic fl,
                        input logic ce, input logic [DW-1:0] d, input string name);
        w_en = w; r_en = r; flush = fl; clr_err = ce; data_in = d;
        @(posedge clk);
        model_edge(w, r, fl, ce, d);
        #1;
        check_all(name);
    endtask

    task automatic do_reset();
        w_en = 0; r_en = 0; flush = 0; clr_err = 0; data_in = '0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_of = 1'b0; m_uf = 1'b0; m_dout = '0;
        check_all("reset");
        rstn = 1'b1;
    endtask

    initial begin
        // {w, r, flush, clr_err, data, count, of, uf, dout registered, dout fwft}
        tbl[0]  = '{1, 0, 0, 0, 'h11, 1, 0, 0, 'h00, 'h11};
        tbl[1]  = '{1, 0, 0, 0, 'h22, 2, 0, 0, 'h00, 'h11};
        tbl[2]  = '{1, 1, 0, 0, 'h33, 2, 0, 0, 'h11, 'h22};
        tbl[3]  = '{0, 1, 0, 0, 'h00, 1, 0, 0, 'h22, 'h33};
        tbl[4]  = '{0, 1, 0, 0, 'h00, 0, 0, 0, 'h33, 'h00};
        tbl[5]  = '{0, 1, 0, 0, 'h00, 0, 0, 1, 'h33, 'h00};
        tbl[6]  = '{0, 0, 0, 1, 'h00, 0, 0, 0, 'h33, 'h00};
        tbl[7]  = '{0, 1, 0, 1, 'h00, 0, 0, 1, 'h33, 'h00};
        tbl[8]  = '{0, 0, 0, 1, 'h00, 0, 0, 0, 'h33, 'h00};
        tbl[9]  = '{1, 0, 0, 0, 'h44, 1, 0, 0, 'h33, 'h44};
        tbl[10] = '{1, 0, 1, 0, 'h55, 0, 0, 0, 'h00, 'h00};
        tbl[11] = '{0, 0, 0, 0, 'h00, 0, 0, 0, 'h00, 'h00};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].w != 0, tbl[i].r != 0, tbl[i].fl != 0, tbl[i].ce != 0,
                 DW'(tbl[i].d), $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d of", i), 64'(of), 64'(tbl[i].of_e));
            chk($sformatf("tbl%0d uf", i), 64'(uf), 64'(tbl[i].uf_e));
`ifdef FIFO_FWFT_EN
            chk($sformatf("tbl%0d dout", i), 64'(data_out), 64'(tbl[i].dout_fwft));
`else
            chk($sformatf("tbl%0d dout", i), 64'(data_out), 64'(tbl[i].dout_reg));
`endif
        end

        // Fill, overflow, drain in order, underflow.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, DW'(i), $sformatf("fill%0d", i));
        end
        chk("full after 16", 64'(full), 64'd1);
        step(1, 0, 0, 0, 8'hAA, "overflow");
        chk("of after overflow", 64'(of), 64'd1);
        chk("count after overflow", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 0, 8'h00, $sformatf("drain%0d", i));
`ifdef FIFO_FWFT_EN
            chk($sformatf("drain%0d dout", i), 64'(data_out), (i < 15) ? 64'(i + 2) : 64'd0);
`else
            chk($sformatf("drain%0d dout", i), 64'(data_out), 64'(i + 1));
`endif
        end
        chk("empty after 16 reads", 64'(empty), 64'd1);
        step(0, 0, 0, 1, 8'h00, "clr_of");
        chk("of cleared", 64'(of), 64'd0);
        step(0, 1, 0, 0, 8'h00, "underflow");
        chk("uf set", 64'(uf), 64'd1);
        chk("count at underflow", 64'(count), 64'd0);
`ifndef FIFO_FWFT_EN
        chk("dout held at underflow", 64'(data_out), 64'h10);
`endif

        // Threshold flag transitions while filling.
        do_reset();
        afull_th = 5'd12; aempty_th = 5'd3;
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, DW'(i * 3), $sformatf("thr%0d", i));
            chk($sformatf("ame@%0d", i), 64'(ame), 64'(i <= 3));
            chk($sformatf("hf@%0d", i), 64'(hf), 64'(i >= 8));
            chk($sformatf("amf@%0d", i), 64'(amf), 64'(i >= 12));
        end

        // Steady state with simultaneous read/write, then flush.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, DW'(8'h40 + i), "pre10");
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, DW'(8'h80 + i), $sformatf("rw%0d", i));
            chk($sformatf("rw%0d count", i), 64'(count), 64'd10);
        end
        step(0, 0, 1, 0, 8'h00, "flush");
        chk("count after flush", 64'(count), 64'd0);
        chk("empty after flush", 64'(empty), 64'd1);

`ifdef FIFO_FWFT_EN
        do_reset();
        step(1, 0, 0, 0, 8'h5C, "fwft");
        chk("fwft dout", 64'(data_out), 64'h5C);
`endif

        // Asynchronous reset between edges, with a write pending.
        do_reset();
        step(0, 1, 0, 0, 8'h00, "pre-uf");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, DW'(8'hC0 + i), "pre-rst");
        w_en = 1'b1; data_in = 8'hEE;
        #3;
        rstn = 1'b0;
        #1;
        chk("async rst count", 64'(count), 64'd0);
        chk("async rst empty", 64'(empty), 64'd1);
        chk("async rst uf", 64'(uf), 64'd0);
        chk("async rst dout", 64'(data_out), 64'd0);
        @(posedge clk);
        #1;
        chk("held in rst count", 64'(count), 64'd0);
        q.delete(); m_of = 1'b0; m_uf = 1'b0; m_dout = '0;
        rstn = 1'b1;
        step(0, 1, 0, 0, 8'h00, "post-rst read");

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int pw;
            pw = ((i / 100) % 2 == 0) ? 75 : 25;
            if ($urandom_range(0, 31) == 0) begin
                afull_th = 5'($urandom_range(0, 17));
                aempty_th = 5'($urandom_range(0, 17));
            end
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 15) == 0,
                 8'($urandom), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
